cold_climate_ctrl: RTL

//  Downstream consumer of the DHT11 reader. Schedules periodic sensor reads via sensor_en and

---
 rtl/cold_pkg.sv | 27 ++
 rtl/cold_climate_ctrl_if.sv | 25 ++
 rtl/cold_avg_filter.sv | 73 +++++++
 rtl/cold_climate_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cold_pkg.sv
// Shared definitions for the cold-room controller: FSM encoding, data widths,
// setpoint defaults and the compressor threshold helpers.
package cold_pkg;

  localparam int DEG_W = 8;
  localparam int RH_W  = 8;

  localparam int TEMP_SET_DEF  = 4;
  localparam int TEMP_HYST_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_FILTER  = 2'd2,
    ST_CONTROL = 2'd3
  } ctrl_state_t;

  // Thresholds are 9 bits so SET+HYST cannot wrap for 8-bit setpoints.
  function automatic logic [8:0] on_threshold(input int set, input int hyst);
    return 9'(set + hyst);
  endfunction

  function automatic logic [8:0] off_threshold(input int set, input int hyst);
    return (set > hyst) ? 9'(set - hyst) : 9'd0;
  endfunction

endpackage

// File: rtl/cold_climate_ctrl_if.sv
// Link between the controller and the DHT11 reader: read enable out,
// validated sample pulse and data back.
interface cold_climate_ctrl_if;
  import cold_pkg::*;

  logic             sensor_en;
  logic             sensor_valid;
  logic [RH_W-1:0]  sensor_hum;
  logic [DEG_W-1:0] sensor_temp;

  modport master (
    output sensor_en,
    input  sensor_valid,
    input  sensor_hum,
    input  sensor_temp
  );

  modport slave (
    input  sensor_en,
    output sensor_valid,
    output sensor_hum,
    output sensor_temp
  );

endinterface

// File: rtl/cold_avg_filter.sv
// Power-of-2 moving average with ring buffer and running sum; the first
// sample after reset fills every slot so the average starts at that value.
module cold_avg_filter
  import cold_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int W        = DEG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_strobe,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_avg,
  output logic         o_primed
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = W + AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [W-1:0]  w_ring [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [SW-1:0] r_sum;
  logic [W-1:0]  r_avg;
  logic          r_primed;
  logic [W-1:0]  w_oldest;
  logic [SW-1:0] w_sum_next;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ring
    logic [W-1:0] r_entry;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_entry <= '0;
      end else if (i_strobe && (!r_primed || r_ptr == PW'(gi))) begin
        r_entry <= i_data;
      end
    end

    assign w_ring[gi] = r_entry;
  end

  assign w_oldest = w_ring[r_ptr];

  always_comb begin
    w_sum_next = SW'(i_data) << AVG_LOG2;
    if (r_primed) begin
      w_sum_next = r_sum - SW'(w_oldest) + SW'(i_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_sum    <= '0;
      r_avg    <= '0;
      r_primed <= 1'b0;
    end else if (i_strobe) begin
      r_sum    <= w_sum_next;
      r_avg    <= w_sum_next[SW-1:AVG_LOG2];
      r_primed <= 1'b1;
      if (!r_primed || r_ptr == PW'(DEPTH - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign o_avg    = r_avg;
  assign o_primed = r_primed;

endmodule

// File: rtl/cold_climate_ctrl.sv
// Cold-room controller: schedules DHT11 reads, filters the samples and drives
// the compressor with hysteresis, a minimum-off guard and a sensor-fault override.
module cold_climate_ctrl
  import cold_pkg::*;
#(
  parameter int SAMPLE_PERIOD_CYC = 2_000_000,
  parameter int READ_TIMEOUT_CYC  = 100_000,
  parameter int AVG_LOG2          = 2,
  parameter int TEMP_SET          = TEMP_SET_DEF,
  parameter int TEMP_HYST         = TEMP_HYST_DEF,
  parameter int FAIL_LIMIT        = 3,
  parameter int MIN_OFF_CYC       = 180_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_run,
  cold_climate_ctrl_if.master        sensor_if,
  output logic [RH_W-1:0]            o_avg_hum,
  output logic [DEG_W-1:0]           o_avg_temp,
  output logic                       o_avg_valid,
  output logic                       o_sample_tick,
  output logic                       o_compressor_on,
  output logic                       o_sensor_fault
);

  localparam int PER_W  = (SAMPLE_PERIOD_CYC > 1) ? $clog2(SAMPLE_PERIOD_CYC) : 1;
  localparam int TO_W   = (READ_TIMEOUT_CYC > 1) ? $clog2(READ_TIMEOUT_CYC) : 1;
  localparam int MOFF_W = (MIN_OFF_CYC > 1) ? $clog2(MIN_OFF_CYC) : 1;
  localparam int FAIL_W = $clog2(FAIL_LIMIT + 1);

  localparam logic [8:0] ON_THRESH  = on_threshold(TEMP_SET, TEMP_HYST);
  localparam logic [8:0] OFF_THRESH = off_threshold(TEMP_SET, TEMP_HYST);

  ctrl_state_t        r_state;
  ctrl_state_t        w_state_next;
  logic               r_run_d;
  logic [PER_W-1:0]   r_period_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [FAIL_W-1:0]  r_fail_cnt;
  logic [MOFF_W-1:0]  r_minoff_cnt;
  logic [RH_W-1:0]    r_hum_lat;
  logic [DEG_W-1:0]   r_temp_lat;
  logic               r_sample_tick;
  logic               r_comp;
  logic               r_fault;

  logic w_run_rise;
  logic w_period_hit;
  logic w_go_read;
  logic w_read_ok;
  logic w_read_to;
  logic w_filter_stb;
  logic w_ctrl_eval;
  logic w_fault_now;
  logic w_on_cond;
  logic w_off_cond;
  logic w_minoff_done;
  logic w_comp_off;
  logic w_t_primed;
  logic w_h_primed;
  logic [DEG_W-1:0] w_avg_temp;
  logic [RH_W-1:0]  w_avg_hum;

  // run is low throughout IDLE before a rising edge, so the rise itself is the
  // first-read request; no separate pending flag is needed.
  assign w_run_rise   = i_run & ~r_run_d;
  assign w_period_hit = (r_period_cnt == PER_W'(SAMPLE_PERIOD_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_run_d <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_run_d <= i_run;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_go_read    = 1'b0;
    w_read_ok    = 1'b0;
    w_read_to    = 1'b0;
    w_filter_stb = 1'b0;
    w_ctrl_eval  = 1'b0;
    if (!i_run) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_period_hit || w_run_rise) begin
            w_go_read    = 1'b1;
            w_state_next = ST_READ;
          end
        end
        ST_READ: begin
          if (sensor_if.sensor_valid) begin
            w_read_ok    = 1'b1;
            w_state_next = ST_FILTER;
          end else if (r_to_cnt == TO_W'(READ_TIMEOUT_CYC - 1)) begin
            w_read_to    = 1'b1;
            w_state_next = ST_CONTROL;
          end
        end
        ST_FILTER: begin
          w_filter_stb = 1'b1;
          w_state_next = ST_CONTROL;
        end
        ST_CONTROL: begin
          w_ctrl_eval  = 1'b1;
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign sensor_if.sensor_en = (r_state == ST_READ);

  // Period counter free-runs across all states so read starts stay on a fixed grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if (!i_run || w_go_read || w_period_hit) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt   <= '0;
      r_fail_cnt <= '0;
      r_hum_lat  <= '0;
      r_temp_lat <= '0;
    end else begin
      r_to_cnt <= (r_state == ST_READ) ? r_to_cnt + 1'b1 : '0;
      if (w_read_ok) begin
        r_fail_cnt <= '0;
        r_hum_lat  <= sensor_if.sensor_hum;
        r_temp_lat <= sensor_if.sensor_temp;
      end else if (w_read_to && r_fail_cnt < FAIL_W'(FAIL_LIMIT)) begin
        r_fail_cnt <= r_fail_cnt + 1'b1;
      end
    end
  end

  cold_avg_filter #(.AVG_LOG2(AVG_LOG2), .W(RH_W)) u_hum_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_strobe (w_filter_stb),
    .i_data   (r_hum_lat),
    .o_avg    (w_avg_hum),
    .o_primed (w_h_primed)
  );

  cold_avg_filter #(.AVG_LOG2(AVG_LOG2), .W(DEG_W)) u_temp_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_strobe (w_filter_stb),
    .i_data   (r_temp_lat),
    .o_avg    (w_avg_temp),
    .o_primed (w_t_primed)
  );

  assign w_fault_now   = (r_fail_cnt >= FAIL_W'(FAIL_LIMIT));
  assign w_on_cond     = w_fault_now ||
                         (o_avg_valid && ({1'b0, w_avg_temp} >= ON_THRESH));
  assign w_off_cond    = !w_fault_now && ({1'b0, w_avg_temp} <= OFF_THRESH);
  assign w_minoff_done = (r_minoff_cnt == '0);
  assign w_comp_off    = r_comp && (!i_run || (w_ctrl_eval && w_off_cond));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_comp        <= 1'b0;
      r_fault       <= 1'b0;
      r_sample_tick <= 1'b0;
    end else begin
      r_sample_tick <= w_filter_stb;
      if (w_ctrl_eval) begin
        r_fault <= w_fault_now;
      end
      if (w_comp_off) begin
        r_comp <= 1'b0;
      end else if (w_ctrl_eval && !r_comp && w_on_cond && w_minoff_done) begin
        r_comp <= 1'b1;
      end
    end
  end

  // Loaded with N-1 so a restart needs at least MIN_OFF_CYC cycles of off time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_minoff_cnt <= '0;
    end else if (w_comp_off) begin
      r_minoff_cnt <= MOFF_W'(MIN_OFF_CYC - 1);
    end else if (!w_minoff_done) begin
      r_minoff_cnt <= r_minoff_cnt - 1'b1;
    end
  end

  assign o_avg_hum       = w_avg_hum;
  assign o_avg_temp      = w_avg_temp;
  assign o_avg_valid     = w_t_primed & w_h_primed;
  assign o_sample_tick   = r_sample_tick;
  assign o_compressor_on = r_comp;
  assign o_sensor_fault  = r_fault;

endmodule
